div_result_stage: RTL and testbench

Registered output stage directly downstream of the combinational signed divider in the arithmetic unit. It captures each dividend/divisor/quotient/remainder tuple on a valid/ready handshake and derives status flags (divide-by-zero, overflow, negative, zero). Results are buffered in a small FIFO and released to the ALU result bus on a second valid/ready handshake. The stage also keeps saturating exception counters for debug readout.

---
 rtl/alu_pkg.sv | 19 +
 rtl/sync_fifo.sv | 71 +++++++
 rtl/div_result_stage.sv | 103 ++++++++++
 tb/tb_div_result_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared arithmetic-unit definitions: flag bit positions and the divider result record.
package alu_pkg;

   localparam int unsigned ALU_W  = 8;
   localparam int unsigned FLAG_W = 4;

   localparam int unsigned FLAG_DZ   = 3;
   localparam int unsigned FLAG_OVF  = 2;
   localparam int unsigned FLAG_NEG  = 1;
   localparam int unsigned FLAG_ZERO = 0;

   // Field order here is the bit layout of every buffered divider result.
   typedef struct packed {
      logic [ALU_W-1:0]  quotient;
      logic [ALU_W-1:0]  remainder;
      logic [FLAG_W-1:0] flags;
   } div_result_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with read/write pointers and an occupancy counter; storage clears on reset.
module sync_fifo #(
   parameter int unsigned WIDTH = 20,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             not_full,
   output logic             not_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PtrOne  = AW'(1);
   localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
   localparam logic [AW:0]   FullCnt = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign not_full  = (count_q < FullCnt);
   assign not_empty = (count_q != '0);
   assign rdata     = mem_q[rd_ptr_q];

   // Qualify requests against registered state so a caller can never overrun or underrun.
   assign push_ok = push && not_full;
   assign pop_ok  = pop && not_empty;

   // Next-state for storage, pointers (wrap modulo DEPTH) and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PtrOne;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
   end

   // State register with synchronous reset that discards all buffered entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/div_result_stage.sv
// Registered result stage behind the signed divider: flag derivation, buffering, exception counters.
module div_result_stage
   import alu_pkg::*;
#(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_dividend,
   input  logic [W-1:0]     in_divisor,
   input  logic [W-1:0]     in_quotient,
   input  logic [W-1:0]     in_remainder,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_quotient,
   output logic [W-1:0]     out_remainder,
   output logic [3:0]       out_flags,
   input  logic             clr_counts,
   output logic [CNT_W-1:0] dz_count,
   output logic [CNT_W-1:0] ovf_count
);

   // Entry layout {quotient, remainder, flags} matches div_result_t at W == ALU_W.
   localparam int unsigned EntryW = 2 * W + FLAG_W;
   localparam logic [W-1:0]     MinNeg = {1'b1, {(W - 1){1'b0}}};
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic              dz, ovf;
   logic [FLAG_W-1:0] flags;
   logic              push, pop;
   logic [EntryW-1:0] wdata, rdata;
   logic [CNT_W-1:0]  dz_cnt_q, dz_cnt_d;
   logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

   // Status flags from the raw divider tuple; results themselves are never corrected.
   always_comb begin
      dz                = (in_divisor == '0);
      ovf               = (in_divisor == '1) && (in_dividend == MinNeg);
      flags             = '0;
      flags[FLAG_DZ]    = dz;
      flags[FLAG_OVF]   = ovf;
      flags[FLAG_NEG]   = in_quotient[W-1];
      flags[FLAG_ZERO]  = (in_quotient == '0) || dz;
   end

   assign push  = in_valid && in_ready;
   assign pop   = out_valid && out_ready;
   assign wdata = {in_quotient, in_remainder, flags};

   sync_fifo #(
      .WIDTH (EntryW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .wdata     (wdata),
      .rdata     (rdata),
      .not_full  (in_ready),
      .not_empty (out_valid)
   );

   assign out_quotient  = rdata[EntryW-1 -: W];
   assign out_remainder = rdata[FLAG_W +: W];
   assign out_flags     = rdata[FLAG_W-1:0];

   // Saturating exception counters; clear wins over a same-cycle increment.
   always_comb begin
      dz_cnt_d  = dz_cnt_q;
      ovf_cnt_d = ovf_cnt_q;
      if (clr_counts) begin
         dz_cnt_d  = '0;
         ovf_cnt_d = '0;
      end else if (push) begin
         if (dz && (dz_cnt_q != '1)) begin
            dz_cnt_d = dz_cnt_q + CntOne;
         end
         if (ovf && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + CntOne;
         end
      end
   end

   // Counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         dz_cnt_q  <= '0;
         ovf_cnt_q <= '0;
      end else begin
         dz_cnt_q  <= dz_cnt_d;
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign dz_count  = dz_cnt_q;
   assign ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_div_result_stage.sv
// Self-checking bench for div_result_stage: directed steps plus a randomized stream vs a queue model.
module tb_div_result_stage;

   localparam int W     = 8;
   localparam int DEPTH = 2;
   localparam int CNT_W = 8;
   localparam int CMAX  = 255;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_dividend = '0;
   logic [W-1:0]     in_divisor = '0;
   logic [W-1:0]     in_quotient = '0;
   logic [W-1:0]     in_remainder = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [W-1:0]     out_quotient;
   logic [W-1:0]     out_remainder;
   logic [3:0]       out_flags;
   logic             clr_counts = 1'b0;
   logic [CNT_W-1:0] dz_count;
   logic [CNT_W-1:0] ovf_count;

   always #5 clk = ~clk;

   div_result_stage #(
      .W     (W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_dividend   (in_dividend),
      .in_divisor    (in_divisor),
      .in_quotient   (in_quotient),
      .in_remainder  (in_remainder),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_quotient  (out_quotient),
      .out_remainder (out_remainder),
      .out_flags     (out_flags),
      .clr_counts    (clr_counts),
      .dz_count      (dz_count),
      .ovf_count     (ovf_count)
   );

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic [3:0] f;
   } exp_t;

   exp_t mq[$];
   int   dz_exp  = 0;
   int   ovf_exp = 0;
   int   total   = 0;
   int   bad     = 0;

   // Flags from signed integer values of the tuple.
   function automatic logic [3:0] ref_flags(input int a, input int b, input int q);
      logic [3:0] f;
      f    = '0;
      f[3] = (b == 0);
      f[2] = (b == -1) && (a == -128);
      f[1] = (q < 0);
      f[0] = (q == 0) || (b == 0);
      return f;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
      check({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
      if (mq.size() > 0) begin
         check({tag, ".q"}, 32'(out_quotient), 32'(mq[0].q));
         check({tag, ".r"}, 32'(out_remainder), 32'(mq[0].r));
         check({tag, ".flags"}, 32'(out_flags), 32'(mq[0].f));
      end
      check({tag, ".dz_count"}, 32'(dz_count), 32'(dz_exp));
      check({tag, ".ovf_count"}, 32'(ovf_count), 32'(ovf_exp));
   endtask

   // One clock: drive inputs, advance the model on the edge, then check outputs.
   task automatic cycle(input string tag, input bit vld, input int a, input int b, input int q,
                        input int r, input bit ordy, input bit clr, output bit acc);
      bit   push, pop;
      exp_t e;
      in_valid     = vld;
      in_dividend  = 8'(a);
      in_divisor   = 8'(b);
      in_quotient  = 8'(q);
      in_remainder = 8'(r);
      out_ready    = ordy;
      clr_counts   = clr;
      push = vld && (mq.size() < DEPTH);
      pop  = ordy && (mq.size() > 0);
      e.q  = 8'(q);
      e.r  = 8'(r);
      e.f  = ref_flags(a, b, q);
      @(posedge clk);
      #1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (clr) begin
         dz_exp  = 0;
         ovf_exp = 0;
      end else if (push) begin
         if (e.f[3] && dz_exp < CMAX) dz_exp++;
         if (e.f[2] && ovf_exp < CMAX) ovf_exp++;
      end
      acc        = push;
      in_valid   = 1'b0;
      clr_counts = 1'b0;
      check_all(tag);
   endtask

   task automatic gen(output int a, output int b, output int q, output int r);
      int sel;
      sel = int'($urandom_range(0, 9));
      a   = int'($urandom_range(0, 255)) - 128;
      b   = int'($urandom_range(0, 255)) - 128;
      if (sel == 0) b = 0;
      if (sel == 1) begin
         a = -128;
         b = -1;
      end
      if (b == 0) begin
         q = 0;
         r = 0;
      end else if (a == -128 && b == -1) begin
         q = 127;
         r = 0;
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   task automatic drain(input string tag);
      bit acc;
      for (int i = 0; i < 8 && mq.size() > 0; i++) cycle(tag, 0, 0, 1, 0, 0, 1, 0, acc);
      check({tag, ".empty"}, 32'(mq.size()), 32'(0));
   endtask

   task automatic do_reset(input string tag);
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete();
      dz_exp  = 0;
      ovf_exp = 0;
      check({tag, ".in_ready"}, 32'(in_ready), 32'(1));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(0));
      check({tag, ".q"}, 32'(out_quotient), 32'(0));
      check({tag, ".r"}, 32'(out_remainder), 32'(0));
      check({tag, ".flags"}, 32'(out_flags), 32'(0));
      check({tag, ".dz"}, 32'(dz_count), 32'(0));
      check({tag, ".ovf"}, 32'(ovf_count), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      bit acc;
      int a, b, q, r;
      bit vld, ordy;
      int wait_n;

      @(posedge clk);
      do_reset("reset");

      // Basic push: visible next cycle.
      cycle("p100_7", 1, 100, 7, 14, 2, 1, 0, acc);
      check("p100_7.q_const", 32'(out_quotient), 32'(14));
      check("p100_7.r_const", 32'(out_remainder), 32'(2));
      check("p100_7.f_const", 32'(out_flags), 32'(4'b0000));

      // Overflow tuple, then a negative quotient.
      cycle("ovf", 1, -128, -1, 127, 0, 1, 0, acc);
      check("ovf.f_const", 32'(out_flags), 32'(4'b0100));
      check("ovf.cnt_const", 32'(ovf_count), 32'(1));
      cycle("neg", 1, -20, 3, -6, -2, 1, 0, acc);
      check("neg.f_const", 32'(out_flags), 32'(4'b0010));
      check("neg.q_const", 32'(out_quotient), 32'(8'hFA));

      // Divide by zero, then saturate the counter and clear with a same-cycle push.
      cycle("dz", 1, 5, 0, 0, 0, 1, 0, acc);
      check("dz.f_const", 32'(out_flags), 32'(4'b1001));
      check("dz.cnt_const", 32'(dz_count), 32'(1));
      for (int i = 0; i < 300; i++) cycle("dzsat", 1, 5, 0, 0, 0, 1, 0, acc);
      check("dzsat.cnt_const", 32'(dz_count), 32'(255));
      cycle("dzclr", 1, 5, 0, 0, 0, 1, 1, acc);
      check("dzclr.cnt_const", 32'(dz_count), 32'(0));
      drain("drain1");

      // Backpressure: third tuple held upstream until space frees.
      cycle("bp1", 1, 9, 2, 4, 1, 0, 0, acc);
      cycle("bp2", 1, 10, 3, 3, 1, 0, 0, acc);
      check("bp2.in_ready_const", 32'(in_ready), 32'(0));
      cycle("bp3a", 1, 11, 4, 2, 3, 0, 0, acc);
      check("bp3a.accepted", 32'(acc), 32'(0));
      wait_n = 0;
      acc    = 1'b0;
      while (!acc && wait_n < 10) begin
         cycle("bp3", 1, 11, 4, 2, 3, 1, 0, acc);
         wait_n++;
      end
      check("bp3.accepted", 32'(acc), 32'(1));
      drain("drain2");

      // Randomized stream with random backpressure.
      for (int i = 0; i < 400; i++) begin
         gen(a, b, q, r);
         vld  = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 1) != 0);
         cycle("rand", vld, a, b, q, r, ordy, ($urandom_range(0, 63) == 0), acc);
      end
      drain("drain3");

      // Reset with two entries buffered and nonzero counters.
      cycle("prer1", 1, -128, -1, 127, 0, 0, 0, acc);
      cycle("prer2", 1, 7, 0, 0, 0, 0, 0, acc);
      check("prer.full", 32'(in_ready), 32'(0));
      do_reset("midrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
